exe_to_wb_datapath: RTL

EXE_TO_WB_DATAPATH -- requirements
Module: exe_to_wb_datapath

---
 rtl/exe_to_wb_datapath.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/exe_to_wb_datapath.sv
// rtl/exe_to_wb_datapath.sv - ARM execute-to-writeback pipeline slice (condition check, NZCV, M and W registers)
//
// Ports:
//   clk, reset                 : clock; synchronous active-high reset
//   CondE, FlagsE              : condition field and NZCV flags of the execute instruction
//   ALUFlags, FlagWE           : NZCV from the ALU; FlagWE[1] writes NZ, FlagWE[0] writes CV
//   PCSE, RegWE, MemWE,
//   MemtoRegE                  : execute-stage controls
//   ALUResultE, WriteDataE,
//   WA3E                       : execute-stage data and destination register
//   StallM, FlushM             : hazard control at the E->M boundary
//   ReadDataM                  : data-memory read of ALUOutM
//   ALUOutM, WriteDataM,
//   MemWriteM                  : data-memory interface
//   WD3, WE3, A3               : register-file write port
//   PCSrcW, Flags              : PC select from writeback; architectural NZCV

module exe_to_wb_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  CondE,
    input  logic [3:0]  FlagsE,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagWE,
    input  logic        PCSE,
    input  logic        RegWE,
    input  logic        MemWE,
    input  logic        MemtoRegE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WA3E,
    input  logic        StallM,
    input  logic        FlushM,
    input  logic [31:0] ReadDataM,
    output logic [31:0] ALUOutM,
    output logic [31:0] WriteDataM,
    output logic        MemWriteM,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic [3:0]  A3,
    output logic        PCSrcW,
    output logic [3:0]  Flags
);

    logic        w_n, w_z, w_c, w_v;
    logic        w_cond_ex;
    logic        w_load;

    logic        r_reg_w_m, r_mem_w_m, r_pcs_m, r_mem_to_reg_m;
    logic [31:0] r_alu_out_m, r_write_data_m;
    logic [3:0]  r_wa3_m;

    logic        r_reg_w_w, r_pcs_w, r_mem_to_reg_w;
    logic [31:0] r_alu_out_w, r_read_data_w;
    logic [3:0]  r_wa3_w;

    logic [3:0]  r_flags;

    assign {w_n, w_z, w_c, w_v} = FlagsE;

    always_comb begin
        w_cond_ex = 1'b0;
        case (CondE)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // A stalled or flushed instruction must not commit flags or advance into M.
    assign w_load = ~StallM & ~FlushM;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_w_m      <= 1'b0;
            r_mem_w_m      <= 1'b0;
            r_pcs_m        <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_alu_out_m    <= 32'd0;
            r_write_data_m <= 32'd0;
            r_wa3_m        <= 4'd0;
            r_reg_w_w      <= 1'b0;
            r_pcs_w        <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
            r_alu_out_w    <= 32'd0;
            r_read_data_w  <= 32'd0;
            r_wa3_w        <= 4'd0;
            r_flags        <= 4'd0;
        end else begin
            if (w_load && FlagWE[1] && w_cond_ex) r_flags[3:2] <= ALUFlags[3:2];
            if (w_load && FlagWE[0] && w_cond_ex) r_flags[1:0] <= ALUFlags[1:0];

            // While M is held, W takes a bubble so the held instruction is not written twice.
            if (StallM) begin
                r_reg_w_w <= 1'b0;
                r_pcs_w   <= 1'b0;
            end else begin
                r_reg_w_w      <= r_reg_w_m;
                r_pcs_w        <= r_pcs_m;
                r_mem_to_reg_w <= r_mem_to_reg_m;
                r_alu_out_w    <= r_alu_out_m;
                r_read_data_w  <= ReadDataM;
                r_wa3_w        <= r_wa3_m;
            end

            // Flush wins over stall; only the controls need clearing to form a bubble.
            if (FlushM) begin
                r_reg_w_m      <= 1'b0;
                r_mem_w_m      <= 1'b0;
                r_pcs_m        <= 1'b0;
                r_mem_to_reg_m <= 1'b0;
            end else if (!StallM) begin
                r_reg_w_m      <= RegWE & w_cond_ex;
                r_mem_w_m      <= MemWE & w_cond_ex;
                r_pcs_m        <= PCSE & w_cond_ex;
                r_mem_to_reg_m <= MemtoRegE;
                r_alu_out_m    <= ALUResultE;
                r_write_data_m <= WriteDataE;
                r_wa3_m        <= WA3E;
            end
        end
    end

    assign ALUOutM    = r_alu_out_m;
    assign WriteDataM = r_write_data_m;
    assign MemWriteM  = r_mem_w_m;
    assign WE3        = r_reg_w_w;
    assign A3         = r_wa3_w;
    assign PCSrcW     = r_pcs_w;
    assign WD3        = r_mem_to_reg_w ? r_read_data_w : r_alu_out_w;
    assign Flags      = r_flags;

endmodule
